// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the hardwired control sequencer.
//   - FSM state enum and instruction class enum
//   - opcode, OPR_sel and alu_op encodings
//   - ctrlsig field offsets and a helper that packs a control word
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC1,
    S_EXEC2,
    S_FETCH_TGT,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    CL_NOP,
    CL_LDAC,
    CL_STAC,
    CL_INC,
    CL_CLR,
    CL_ALU,
    CL_JMPZ,
    CL_END
  } iclass_e;

  // Opcodes (ir[7:3])
  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_LDAC = 5'd1;
  localparam logic [4:0] OP_STAC = 5'd2;
  localparam logic [4:0] OP_INC  = 5'd3;
  localparam logic [4:0] OP_CLR  = 5'd4;
  localparam logic [4:0] OP_ADD  = 5'd5;
  localparam logic [4:0] OP_SUB  = 5'd6;
  localparam logic [4:0] OP_AND  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_MUL  = 5'd9;
  localparam logic [4:0] OP_JMPZ = 5'd10;
  localparam logic [4:0] OP_END  = 5'd31;

  // OPR demux select
  localparam logic [2:0] SEL_NONE  = 3'd0;
  localparam logic [2:0] SEL_WTR   = 3'd1;
  localparam logic [2:0] SEL_INC   = 3'd2;
  localparam logic [2:0] SEL_RESET = 3'd3;
  localparam logic [2:0] SEL_WTA   = 3'd4;

  // ALU operation select
  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_MUL  = 3'd5;

  // ctrlsig field offsets
  localparam int unsigned CS_OPR_LSB = 6;
  localparam int unsigned CS_ALU_LSB = 3;
  localparam int unsigned CS_ALU_WR  = 2;
  localparam int unsigned CS_AC_WR   = 1;
  localparam int unsigned CS_WTA     = 0;

  function automatic logic [8:0] pack_ctrl(input logic [2:0] opr_sel,
                                           input logic [2:0] alu_op,
                                           input logic       alu_wr,
                                           input logic       ac_wr,
                                           input logic       wta);
    logic [8:0] w;
    w = '0;
    w[CS_OPR_LSB +: 3] = opr_sel;
    w[CS_ALU_LSB +: 3] = alu_op;
    w[CS_ALU_WR]       = alu_wr;
    w[CS_AC_WR]        = ac_wr;
    w[CS_WTA]          = wta;
    return w;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode decoder.
//   opcode_i  : opcode field of the IR
//   iclass_o  : instruction class driving FSM sequencing
//   alu_op_o  : ALU operation for ALU-class instructions, PASS otherwise
//   opr_sel_o : OPR demux select used in EXEC1
//   illegal_o : opcode is undefined (decoded as NOP)
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPC_W = 5
) (
  input  logic [OPC_W-1:0] opcode_i,
  output iclass_e          iclass_o,
  output logic [2:0]       alu_op_o,
  output logic [2:0]       opr_sel_o,
  output logic             illegal_o
);

  always_comb begin
    iclass_o  = CL_NOP;
    alu_op_o  = ALU_PASS;
    opr_sel_o = SEL_NONE;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_NOP:  iclass_o = CL_NOP;
      OP_LDAC: begin iclass_o = CL_LDAC; opr_sel_o = SEL_WTA;   end
      OP_STAC: begin iclass_o = CL_STAC; opr_sel_o = SEL_WTR;   end
      OP_INC:  begin iclass_o = CL_INC;  opr_sel_o = SEL_INC;   end
      OP_CLR:  begin iclass_o = CL_CLR;  opr_sel_o = SEL_RESET; end
      OP_ADD:  begin iclass_o = CL_ALU;  opr_sel_o = SEL_WTA; alu_op_o = ALU_ADD; end
      OP_SUB:  begin iclass_o = CL_ALU;  opr_sel_o = SEL_WTA; alu_op_o = ALU_SUB; end
      OP_AND:  begin iclass_o = CL_ALU;  opr_sel_o = SEL_WTA; alu_op_o = ALU_AND; end
      OP_OR:   begin iclass_o = CL_ALU;  opr_sel_o = SEL_WTA; alu_op_o = ALU_OR;  end
      OP_MUL:  begin iclass_o = CL_ALU;  opr_sel_o = SEL_WTA; alu_op_o = ALU_MUL; end
      OP_JMPZ: iclass_o = CL_JMPZ;
      OP_END:  iclass_o = CL_END;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: hardwired control FSM for the single-accumulator datapath.
//   clk, rst        : clock, synchronous active-high reset
//   start           : leave IDLE and begin fetching
//   iram_req/ack    : IRAM fetch handshake; ir_in valid in the ack cycle
//   z               : registered ALU zero flag, used by JMPZ
//   ctrlsig         : {OPR_sel[8:6], alu_op[5:3], alu_write_en, ac_write_en, wta_en}
//   operand         : register select from IR[2:0]
//   ir_write_en, pc_inc, pc_load : single-cycle strobes in fetch ack cycles
//   busy, done      : not IDLE/HALT, in HALT
//   illegal         : sticky undefined-opcode flag
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned OPC_W = 5,
  parameter int unsigned OPR_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   iram_req,
  input  logic                   iram_ack,
  input  logic [OPC_W+OPR_W-1:0] ir_in,
  input  logic                   z,
  output logic [8:0]             ctrlsig,
  output logic [OPR_W-1:0]       operand,
  output logic                   ir_write_en,
  output logic                   pc_inc,
  output logic                   pc_load,
  output logic                   busy,
  output logic                   done,
  output logic                   illegal
);

  state_e                 state_q;
  logic [OPC_W+OPR_W-1:0] ir_q;
  logic                   iram_req_q;
  logic [8:0]             ctrlsig_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   illegal_q;

  iclass_e    dec_class;
  logic [2:0] dec_alu_op;
  logic [2:0] dec_opr_sel;
  logic       dec_illegal;
  logic       fetch_ack;

  ctrl_decode #(.OPC_W(OPC_W)) u_decode (
    .opcode_i  (ir_q[OPC_W+OPR_W-1:OPR_W]),
    .iclass_o  (dec_class),
    .alu_op_o  (dec_alu_op),
    .opr_sel_o (dec_opr_sel),
    .illegal_o (dec_illegal)
  );

  // Ack only counts while a request is outstanding and not during reset.
  assign fetch_ack = iram_req_q & iram_ack & ~rst;

  // Strobes coincide with the ack cycle so the PC/IR capture ir_in directly.
  always_comb begin
    ir_write_en = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    if (fetch_ack) begin
      if (state_q == S_FETCH) begin
        ir_write_en = 1'b1;
        pc_inc      = 1'b1;
      end else if (state_q == S_FETCH_TGT) begin
        pc_load = z;
        pc_inc  = ~z;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      iram_req_q <= 1'b0;
      ctrlsig_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_FETCH;
            iram_req_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_FETCH: begin
          if (fetch_ack) begin
            ir_q       <= ir_in;
            iram_req_q <= 1'b0;
            state_q    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_illegal) illegal_q <= 1'b1;
          case (dec_class)
            CL_JMPZ: begin
              state_q    <= S_FETCH_TGT;
              iram_req_q <= 1'b1;
            end
            CL_END: begin
              state_q <= S_HALT;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
            default: begin
              state_q   <= S_EXEC1;
              ctrlsig_q <= pack_ctrl(dec_opr_sel, dec_alu_op, 1'b0,
                                     dec_class == CL_LDAC,
                                     (dec_class == CL_LDAC) || (dec_class == CL_ALU));
            end
          endcase
        end
        S_EXEC1: begin
          if (dec_class == CL_ALU) begin
            state_q   <= S_EXEC2;
            ctrlsig_q <= pack_ctrl(SEL_NONE, dec_alu_op, 1'b1, 1'b0, 1'b0);
          end else begin
            state_q    <= S_FETCH;
            ctrlsig_q  <= '0;
            iram_req_q <= 1'b1;
          end
        end
        S_EXEC2: begin
          state_q    <= S_FETCH;
          ctrlsig_q  <= '0;
          iram_req_q <= 1'b1;
        end
        S_FETCH_TGT: begin
          // Request stays high: the next instruction fetch follows directly.
          if (fetch_ack) state_q <= S_FETCH;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q    <= S_IDLE;
          iram_req_q <= 1'b0;
          ctrlsig_q  <= '0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign iram_req = iram_req_q;
  assign ctrlsig  = ctrlsig_q;
  assign operand  = ir_q[OPR_W-1:0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed testbench for ctrl_sequencer.
module tb_ctrl_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       iram_req;
  logic       iram_ack;
  logic [7:0] ir_in;
  logic       z;
  logic [8:0] ctrlsig;
  logic [2:0] operand;
  logic       ir_write_en;
  logic       pc_inc;
  logic       pc_load;
  logic       busy;
  logic       done;
  logic       illegal;

  int n_checks = 0;
  int n_fail   = 0;

  ctrl_sequencer #(.OPC_W(5), .OPR_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .iram_req    (iram_req),
    .iram_ack    (iram_ack),
    .ir_in       (ir_in),
    .z           (z),
    .ctrlsig     (ctrlsig),
    .operand     (operand),
    .ir_write_en (ir_write_en),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs are driven and outputs sampled 2ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; iram_ack = 1'b0; ir_in = 8'h00; z = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; iram_ack = 1'b0; ir_in = 8'h00; z = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    n_checks++; if (ctrlsig !== 9'h000) begin n_fail++; $display("FAIL reset_ctrlsig: got %h required 000", ctrlsig); end
    n_checks++; if ({iram_req, ir_write_en, pc_inc, pc_load, busy, done, illegal} !== 7'b0) begin n_fail++;
      $display("FAIL reset_outputs: got %b required 0000000", {iram_req, ir_write_en, pc_inc, pc_load, busy, done, illegal}); end
    n_checks++; if (operand !== 3'd0) begin n_fail++; $display("FAIL reset_operand: got %0d required 0", operand); end
    cyc();
    n_checks++; if (iram_req !== 1'b0) begin n_fail++; $display("FAIL idle_no_start: got %b required 0", iram_req); end
  endtask

  task automatic test_ldac_end();
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;              // FETCH
    n_checks++; if ({iram_req, busy} !== 2'b11) begin n_fail++; $display("FAIL ldac_fetch_req: got %b required 11", {iram_req, busy}); end
    iram_ack = 1'b1; ir_in = 8'h0A; #1;
    n_checks++; if ({ir_write_en, pc_inc, pc_load} !== 3'b110) begin n_fail++;
      $display("FAIL ldac_ack_strobes: got %b required 110", {ir_write_en, pc_inc, pc_load}); end
    cyc(); iram_ack = 1'b0; #1;                     // DECODE
    n_checks++; if ({iram_req, pc_inc, ctrlsig} !== 11'h0) begin n_fail++;
      $display("FAIL ldac_decode: got req=%b inc=%b ctrl=%h required 0 0 000", iram_req, pc_inc, ctrlsig); end
    n_checks++; if (operand !== 3'd2) begin n_fail++; $display("FAIL ldac_operand: got %0d required 2", operand); end
    cyc();                                          // EXEC1
    n_checks++; if (ctrlsig !== 9'h103) begin n_fail++; $display("FAIL ldac_exec1: got %h required 103", ctrlsig); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL ldac_done_early: got %b required 0", done); end
    cyc();                                          // FETCH
    n_checks++; if ({iram_req, ctrlsig} !== {1'b1, 9'h000}) begin n_fail++;
      $display("FAIL end_fetch: got req=%b ctrl=%h required 1 000", iram_req, ctrlsig); end
    iram_ack = 1'b1; ir_in = 8'hF8; #1;
    n_checks++; if (pc_inc !== 1'b1) begin n_fail++; $display("FAIL end_ack_pcinc: got %b required 1", pc_inc); end
    cyc(); iram_ack = 1'b0;                         // DECODE
    cyc();                                          // HALT
    n_checks++; if ({done, busy, ctrlsig} !== {1'b1, 1'b0, 9'h000}) begin n_fail++;
      $display("FAIL end_halt: got done=%b busy=%b ctrl=%h required 1 0 000", done, busy, ctrlsig); end
    start = 1'b1; cyc(); cyc(); start = 1'b0;
    n_checks++; if ({done, iram_req} !== 2'b10) begin n_fail++; $display("FAIL halt_sticky: got %b required 10", {done, iram_req}); end
  endtask

  task automatic test_alu_wait();
    int held;
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;              // FETCH
    ir_in = 8'h2B;
    held = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (iram_req === 1'b1) held++;
      n_checks++; if (ir_write_en !== 1'b0) begin n_fail++; $display("FAIL alu_wait_strobe: got %b required 0", ir_write_en); end
      cyc();
    end
    iram_ack = 1'b1; #1;
    if (iram_req === 1'b1) held++;
    n_checks++; if (held !== 3) begin n_fail++; $display("FAIL alu_req_held: got %0d required 3", held); end
    cyc(); iram_ack = 1'b0;                         // DECODE
    n_checks++; if (iram_req !== 1'b0) begin n_fail++; $display("FAIL alu_req_drop: got %b required 0", iram_req); end
    cyc();                                          // EXEC1
    n_checks++; if (ctrlsig !== 9'h109) begin n_fail++; $display("FAIL alu_exec1: got %h required 109", ctrlsig); end
    cyc();                                          // EXEC2
    n_checks++; if (ctrlsig !== 9'h00C) begin n_fail++; $display("FAIL alu_exec2: got %h required 00C", ctrlsig); end
    n_checks++; if (operand !== 3'd3) begin n_fail++; $display("FAIL alu_operand: got %0d required 3", operand); end
    cyc();                                          // FETCH
    n_checks++; if ({iram_req, ctrlsig} !== {1'b1, 9'h000}) begin n_fail++;
      $display("FAIL alu_next_fetch: got req=%b ctrl=%h required 1 000", iram_req, ctrlsig); end
  endtask

  task automatic test_jmpz(input logic zval);
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;              // FETCH
    iram_ack = 1'b1; ir_in = 8'h50; cyc();          // DECODE
    #1;
    n_checks++; if ({pc_inc, ir_write_en} !== 2'b00) begin n_fail++;
      $display("FAIL ack_without_req: got %b required 00", {pc_inc, ir_write_en}); end
    iram_ack = 1'b0;
    cyc();                                          // FETCH_TGT
    n_checks++; if ({iram_req, ctrlsig} !== {1'b1, 9'h000}) begin n_fail++;
      $display("FAIL jmpz_tgt_req: got req=%b ctrl=%h required 1 000", iram_req, ctrlsig); end
    z = zval; ir_in = 8'h10; iram_ack = 1'b1; #1;
    n_checks++; if ({pc_load, pc_inc, ir_write_en} !== {zval, ~zval, 1'b0}) begin n_fail++;
      $display("FAIL jmpz_z%0d_strobes: got %b required %b", zval, {pc_load, pc_inc, ir_write_en}, {zval, ~zval, 1'b0}); end
    cyc(); iram_ack = 1'b0; z = 1'b0; #1;           // FETCH
    n_checks++; if ({iram_req, busy, pc_load, pc_inc} !== 4'b1100) begin n_fail++;
      $display("FAIL jmpz_z%0d_after: got %b required 1100", zval, {iram_req, busy, pc_load, pc_inc}); end
  endtask

  task automatic test_illegal();
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;              // FETCH
    iram_ack = 1'b1; ir_in = 8'h60; cyc(); iram_ack = 1'b0;   // DECODE
    n_checks++; if (ctrlsig !== 9'h000) begin n_fail++; $display("FAIL illegal_decode_ctrl: got %h required 000", ctrlsig); end
    cyc();                                          // EXEC1
    n_checks++; if ({illegal, ctrlsig} !== {1'b1, 9'h000}) begin n_fail++;
      $display("FAIL illegal_exec1: got ill=%b ctrl=%h required 1 000", illegal, ctrlsig); end
    cyc();                                          // FETCH (NOP)
    iram_ack = 1'b1; ir_in = 8'h00; cyc(); iram_ack = 1'b0;
    cyc(); cyc();                                   // EXEC1, FETCH
    n_checks++; if ({illegal, iram_req} !== 2'b11) begin n_fail++;
      $display("FAIL illegal_sticky: got %b required 11", {illegal, iram_req}); end
    do_reset();
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_cleared: got %b required 0", illegal); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;              // FETCH, no ack yet
    iram_ack = 1'b1; ir_in = 8'h2B; cyc();          // DECODE with operand 3
    iram_ack = 1'b0; cyc(); cyc(); cyc();           // EXEC1, EXEC2, FETCH
    cyc();                                          // still waiting for ack
    rst = 1'b1; start = 1'b1; iram_ack = 1'b1; ir_in = 8'hF8; #1;
    n_checks++; if ({ir_write_en, pc_inc, pc_load} !== 3'b000) begin n_fail++;
      $display("FAIL rst_ack_ignored: got %b required 000", {ir_write_en, pc_inc, pc_load}); end
    cyc();
    rst = 1'b0; start = 1'b0; iram_ack = 1'b0; #1;
    n_checks++; if ({iram_req, busy, done, illegal, ctrlsig, operand} !== 16'h0) begin n_fail++;
      $display("FAIL rst_mid_fetch: got req=%b busy=%b done=%b ill=%b ctrl=%h opr=%0d required all 0",
               iram_req, busy, done, illegal, ctrlsig, operand); end
    cyc();
    n_checks++; if ({iram_req, busy} !== 2'b00) begin n_fail++;
      $display("FAIL rst_start_ignored: got %b required 00", {iram_req, busy}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3] = '{8'h11, 8'h19, 8'h21};
    logic [8:0] exp   [3] = '{9'h040, 9'h080, 9'h0C0};
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;              // FETCH
    for (int i = 0; i < 3; i++) begin
      iram_ack = 1'b1; ir_in = words[i]; cyc(); iram_ack = 1'b0;  // DECODE
      cyc();                                                       // EXEC1
      n_checks++; if ({ctrlsig, operand} !== {exp[i], 3'd1}) begin n_fail++;
        $display("FAIL regop_%0d: got ctrl=%h opr=%0d required %h 1", i, ctrlsig, operand, exp[i]); end
      cyc();                                                       // FETCH
      n_checks++; if ({iram_req, ctrlsig} !== {1'b1, 9'h000}) begin n_fail++;
        $display("FAIL regop_%0d_next: got req=%b ctrl=%h required 1 000", i, iram_req, ctrlsig); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; iram_ack = 1'b0; ir_in = 8'h00; z = 1'b0;
    test_reset();
    test_ldac_end();
    test_alu_wait();
    test_jmpz(1'b1);
    test_jmpz(1'b0);
    test_illegal();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Hardwired control sequencer for the single-accumulator datapath: register file, OPR demux, WTA mux, bus, AC and ALU. It fetches instruction words from IRAM over a req/ack handshake and decodes them. It then drives the 9-bit control word cycle by cycle, replacing the externally supplied `ctrlsig_in` and its separate capture clock. Everything runs on one clock, and the ALU result is registered into AC one cycle after the operands are on the bus.

## Interface
- `OPC_W`, 5: opcode field width (`ir_in[7:3]`).
- `OPR_W`, 3: operand/register-select field width (`ir_in[2:0]`).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  leave IDLE and begin fetching; ignored outside IDLE.
- `iram_req`  out  1  instruction fetch request to IRAM.
- `iram_ack`  in  1  IRAM word valid on `ir_in` this cycle.
- `ir_in`  in  8  instruction word from IRAM.
- `z`  in  1  ALU zero flag, registered by the ALU.
- `ctrlsig`  out  9  bit fields are `[8:6]` OPR_sel, `[5:3]` alu_op, `[2]` alu_write_en, `[1]` ac_write_en, `[0]` wta_en.
- `operand`  out  3  register select from the IR, to the DR register.
- `ir_write_en`, `pc_inc`, `pc_load`  out  1 each  single-cycle strobes.
- `busy`  out  1  high in every state except IDLE and HALT.
- `done`  out  1  high while in HALT.
- `illegal`  out  1  sticky flag for an undefined opcode; cleared only by `rst`.

## Operation
- States: IDLE, FETCH, DECODE, EXEC1, EXEC2, FETCH_TGT, HALT.
- IDLE: on `start` go to FETCH.
- FETCH: hold `iram_req`=1 until `iram_ack`. In the ack cycle, pulse `ir_write_en` and `pc_inc`, latch `ir_in`, then go to DECODE.
- DECODE: `ctrlsig`=0 and `operand`=IR[2:0]. Next state is EXEC1, except FETCH_TGT for JMPZ and HALT for END.
- Instruction classes, with OPR_sel and alu_op codes taken from the package:
  - NOP: EXEC1 drives `ctrlsig`=0, then FETCH.
  - LDAC r: EXEC1 sets OPR_sel=WTA, wta_en=1, ac_write_en=1, then FETCH.
  - ALU r (ADD, SUB, AND, OR, MUL): EXEC1 sets OPR_sel=WTA, wta_en=1 and alu_op. EXEC2 holds alu_op and sets alu_write_en=1, then FETCH.
  - STAC r: EXEC1 sets OPR_sel=WTR, then FETCH.
  - INC r: EXEC1 sets OPR_sel=INC, then FETCH.
  - CLR r: EXEC1 sets OPR_sel=RESET, then FETCH.
  - JMPZ: FETCH_TGT fetches the next word with the same handshake and pulses `pc_inc` on ack. If `z`=1 at ack, it pulses `pc_load` instead of `pc_inc`; the target is `ir_in`, which the PC takes directly. Then FETCH.
  - END: HALT. Stay in HALT until `rst`.
- An undefined opcode executes as NOP and sets `illegal`.
- Outside the cycles listed above, every `ctrlsig` bit is 0. `wta_en` and `ac_write_en` are never both asserted with `alu_write_en`.

## Timing
- Reset values: state IDLE; all outputs 0; IR 0.
- `rst` mid-fetch drops `iram_req` on the next edge. An ack arriving in the reset cycle is ignored.
- `iram_ack` is only sampled while `iram_req`=1. An ack with no request is ignored.
- Fetch latency is 1 cycle plus the IRAM wait cycles.
- Instruction cost, excluding IRAM wait cycles, counted from the FETCH entry edge:
  - NOP, LDAC, STAC, INC, CLR: 3 cycles (FETCH, DECODE, EXEC1).
  - ALU: 4 cycles.
  - JMPZ: 3 cycles plus the target fetch.
- `z` is sampled in the FETCH_TGT ack cycle. The preceding ALU op completed its EXEC2 at least 2 edges earlier, so `z` is stable.
- `start` together with `rst`: reset wins.

## Structure
- Package `ctrl_pkg` holds:
  - State enum.
  - Opcode constants: NOP=0, LDAC=1, STAC=2, INC=3, CLR=4, ADD=5, SUB=6, AND=7, OR=8, MUL=9, JMPZ=10, END=31.
  - OPR_sel codes: NONE=0, WTR=1, INC=2, RESET=3, WTA=4.
  - alu_op codes: PASS=0, ADD=1, SUB=2, AND=3, OR=4, MUL=5.
  - `ctrlsig` field offsets.
- One sub-module, `ctrl_decode`, is combinational: opcode to {class, alu_op, OPR_sel, illegal}. The FSM and IR register stay in `ctrl_sequencer`.

## Test plan
- Reset, then `start`, IRAM acks with 0 wait, words {LDAC 2 = 0x0A, END = 0xF8} → `ctrlsig`=0x103 in EXEC1, then `done`=1 on cycle 7. One `pc_inc` per ack.
- ADD 3 (0x2B) with a 2-cycle ack delay → `iram_req` held 3 cycles. EXEC1 `ctrlsig`=0x109, EXEC2 `ctrlsig`=0x00C, `operand`=3.
- JMPZ with `z`=1, target 0x10 → `pc_load` pulse with `ir_in`=0x10 and no `pc_inc` in that ack. Repeat with `z`=0 → `pc_inc` and no `pc_load`.
- Opcode 0x0C (0x60) → `illegal`=1 and stays 1 through later fetches. `ctrlsig` stays 0 for that instruction.
- Assert `rst` while `iram_req`=1 and ack pending → next cycle IDLE and all outputs 0. `start` asserted in the reset cycle has no effect.
- STAC 1, INC 1, CLR 1 → EXEC1 `ctrlsig` = 0x040, 0x080, 0x0C0 respectively, `operand`=1.
